// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle integer ALU (add/sub/shift-add mul/restoring div) with start/busy/done handshake
module alu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SR_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SR_W-1:0]  SR,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic             cout,
    output logic             err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [SR_W-1:0] OP_ADD = SR_W'(0);
    localparam logic [SR_W-1:0] OP_SUB = SR_W'(1);
    localparam logic [SR_W-1:0] OP_MUL = SR_W'(2);
    localparam logic [SR_W-1:0] OP_DIV = SR_W'(3);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [SR_W-1:0]    op_q;

    // Multiplier: high half accumulates, low half holds the not-yet-consumed multiplier bits.
    logic [2*WIDTH-1:0] acc;
    // Divider: partial remainder plus a quotient register that starts out holding the dividend.
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;

    logic               add_c;
    logic [WIDTH-1:0]   add_s;
    logic               sub_b;
    logic [WIDTH-1:0]   sub_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_fit;
    logic [WIDTH:0]     div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;
    logic               last_iter;

    assign busy = (state != ST_IDLE);

    assign {add_c, add_s} = {1'b0, a_q} + {1'b0, b_q};
    assign {sub_b, sub_d} = {1'b0, a_q} - {1'b0, b_q};

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Two guard bits on the trial subtraction so its MSB is a clean borrow flag.
    assign div_shift    = {rem, quo[WIDTH-1]};
    assign div_diff     = div_shift - {2'b00, b_q};
    assign div_fit      = ~div_diff[WIDTH+1];
    assign div_rem_next = div_fit ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
    assign div_quo_next = {quo[WIDTH-2:0], div_fit};

    assign last_iter = (cnt == LAST_ITER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            acc   <= '0;
            rem   <= '0;
            quo   <= '0;
            done  <= 1'b0;
            Y     <= '0;
            R     <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= SR;
                        cnt   <= '0;
                        acc   <= {{WIDTH{1'b0}}, B};
                        rem   <= '0;
                        quo   <= A;
                        state <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    case (op_q)
                        OP_ADD: begin
                            Y     <= add_s;
                            R     <= '0;
                            cout  <= add_c;
                            err   <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                        OP_SUB: begin
                            Y     <= sub_d;
                            R     <= '0;
                            cout  <= sub_b;
                            err   <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                        OP_MUL: begin
                            acc <= mul_next;
                            cnt <= cnt + CNT_W'(1);
                            if (last_iter) begin
                                Y     <= mul_next[WIDTH-1:0];
                                R     <= mul_next[2*WIDTH-1:WIDTH];
                                cout  <= 1'b0;
                                err   <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                        OP_DIV: begin
                            if (b_q == '0) begin
                                Y     <= '1;
                                R     <= a_q;
                                cout  <= 1'b0;
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                rem <= div_rem_next;
                                quo <= div_quo_next;
                                cnt <= cnt + CNT_W'(1);
                                if (last_iter) begin
                                    Y     <= div_quo_next;
                                    R     <= div_rem_next[WIDTH-1:0];
                                    cout  <= 1'b0;
                                    err   <= 1'b0;
                                    done  <= 1'b1;
                                    state <= ST_DONE;
                                end
                            end
                        end
                        default: begin
                            Y     <= '0;
                            R     <= '0;
                            cout  <= 1'b0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    endcase
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl against an arithmetic reference model
module tb_alu_seq_ctrl;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic [5:0]    sr_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  y_out;
    logic [W-1:0]  r_out;
    logic          cout;
    logic          err;

    alu_seq_ctrl #(.WIDTH(W), .SR_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .SR    (sr_in),
        .busy  (busy),
        .done  (done),
        .Y     (y_out),
        .R     (r_out),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         c;
        logic         e;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    int   cyc = 0;
    bit   busy_m = 0;
    int   release_edge = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, cyc);
        end
    endfunction

    // Reference: results from plain integer arithmetic, latency from the op class.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [5:0] sr, int now);
        exp_t e;
        longint unsigned la = {32'd0, a};
        longint unsigned lb = {32'd0, b};
        longint unsigned t;
        int lat = 2;
        e.y = '0; e.r = '0; e.c = 1'b0; e.e = 1'b0;
        case (sr)
            6'd0: begin t = la + lb; e.y = t[W-1:0]; e.c = t[W]; end
            6'd1: begin t = la - lb; e.y = t[W-1:0]; e.c = (la < lb); end
            6'd2: begin t = la * lb; e.y = t[W-1:0]; e.r = t[2*W-1:W]; lat = W + 1; end
            6'd3: begin
                if (b == 0) begin e.y = '1; e.r = a; e.e = 1'b1; end
                else begin
                    t = la / lb; e.y = t[W-1:0];
                    t = la % lb; e.r = t[W-1:0];
                    lat = W + 1;
                end
            end
            default: e.e = 1'b1;
        endcase
        e.due = now + lat - 1;
        return e;
    endfunction

    // Acceptance/occupancy model: one op in flight, done cycle included, start ignored until after it.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            busy_m = 0;
            held = '{y: '0, r: '0, c: 1'b0, e: 1'b0, due: 0};
        end else if (!busy_m) begin
            if (start) begin
                exp_t e;
                e = model(a_in, b_in, sr_in, cyc);
                exp_q.push_back(e);
                busy_m = 1;
                release_edge = e.due + 1;
            end
        end else if (cyc == release_edge) begin
            busy_m = 0;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            exp_t e;
            chk("busy", {63'd0, busy}, {63'd0, busy_m});
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_edge", 64'(cyc), 64'(e.due));
                    chk("Y", {32'd0, y_out}, {32'd0, e.y});
                    chk("R", {32'd0, r_out}, {32'd0, e.r});
                    chk("cout", {63'd0, cout}, {63'd0, e.c});
                    chk("err", {63'd0, err}, {63'd0, e.e});
                    held = e;
                end
            end else begin
                chk("Y_hold", {32'd0, y_out}, {32'd0, held.y});
                chk("R_hold", {32'd0, r_out}, {32'd0, held.r});
                chk("flags_hold", {62'd0, cout, err}, {62'd0, held.c, held.e});
                if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                    e = exp_q.pop_front();
                    chk("missing_done", 64'(cyc), 64'(e.due));
                    held = e;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy_m || exp_q.size() != 0) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic [5:0] sr);
        start = 1'b1; a_in = a; b_in = b; sr_in = sr;
        tick();
        start = 1'b0; a_in = $urandom; b_in = $urandom; sr_in = 6'($urandom);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return W'($urandom % 16);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; sr_in = '0;
        tick(); tick();
        rst = 1'b0;

        issue(32'hFFFF_FFFF, 32'd1, 6'd0);        wait_idle();
        issue(32'd3, 32'd5, 6'd1);                wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2); wait_idle();
        issue(32'd100, 32'd7, 6'd3);              wait_idle();
        issue(32'd5, 32'd0, 6'd3);                wait_idle();
        issue(32'd1, 32'd1, 6'd9);                wait_idle();
        issue(32'd2, 32'd2, 6'd0);                wait_idle();

        // Start pulse with new operands during a multiply must be ignored.
        issue(32'd1234, 32'd5678, 6'd2);
        repeat (5) tick();
        issue(32'd9, 32'd9, 6'd0);
        wait_idle();

        // Start held high: ignored in the done cycle, accepted right after.
        start = 1'b1; a_in = 32'd7; b_in = 32'd8; sr_in = 6'd0;
        repeat (8) tick();
        start = 1'b0;
        wait_idle();

        // Reset part-way through a divide aborts it without a done pulse.
        issue(32'd100, 32'd7, 6'd3);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        issue(32'd40, 32'd2, 6'd0);
        wait_idle();

        for (int i = 0; i < 4000; i++) begin
            int s;
            start = ($urandom % 4 == 0);
            a_in  = rand_opnd();
            b_in  = rand_opnd();
            s     = int'($urandom % 10);
            sr_in = (s < 9) ? 6'(s % 4) : 6'($urandom_range(4, 63));
            rst   = ($urandom % 500 == 0);
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
        wait_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
